// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter: accepts device transfer requests, commands the DMA engine,
// and hands the memory bus between the CPU and the DMA engine. A one-entry
// pending buffer lets a second request queue up behind the active transfer.
//
// Handshake summary: a request is offered by holding dev_req high for one
// cycle with dev_length/dev_address valid in that cycle; there is no ready,
// so a request that cannot be accepted (zero length, or buffer full) is
// refused with a one-cycle dma_err pulse. The DMA engine holds br high for
// as long as it needs the bus; bg answers it only after the CPU has left the
// bus, and bg drops the cycle after br drops.
module dma_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        dev_req,
    input  logic [15:0] dev_length,
    input  logic [15:0] dev_address,
    input  logic        cpu_mem_active,
    input  logic        br,
    output logic        begin_dma,
    output logic [15:0] length,
    output logic [15:0] target_address,
    output logic        bg,
    output logic        cpu_bus_hold,
    output logic        dma_done,
    output logic        dma_err,
    output logic        busy,
    output logic [15:0] grant_cycles,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_BR  = 3'd2,
        S_WAIT_CPU = 3'd3,
        S_GRANT    = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_to_cnt;
    logic        r_pend_valid;
    logic [15:0] r_pend_len;
    logic [15:0] r_pend_addr;
    logic [15:0] r_length;
    logic [15:0] r_addr;
    logic [15:0] r_grant_cycles;
    logic        r_err;

    logic w_req_zero;
    logic w_req_ok;
    logic w_mid_xfer;

    assign w_req_zero = dev_req && (dev_length == 16'd0);
    assign w_req_ok   = dev_req && (dev_length != 16'd0);
    // States in which a fresh request can only go to the pending buffer
    assign w_mid_xfer = (r_state == S_START) || (r_state == S_WAIT_BR) ||
                        (r_state == S_WAIT_CPU) || (r_state == S_GRANT);

    // Pulse and bus-control outputs are pure decodes of the registered state
    assign begin_dma      = (r_state == S_START);
    assign bg             = (r_state == S_GRANT);
    assign cpu_bus_hold   = (r_state == S_WAIT_CPU) || (r_state == S_GRANT);
    assign dma_done       = (r_state == S_RELEASE);
    assign busy           = (r_state != S_IDLE);
    assign dma_err        = r_err;
    assign length         = r_length;
    assign target_address = r_addr;
    assign grant_cycles   = r_grant_cycles;
    assign dbg_state      = r_state;

    // Arbiter FSM, pending buffer, timeout and grant-cycle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_to_cnt       <= 8'd0;
            r_pend_valid   <= 1'b0;
            r_pend_len     <= 16'd0;
            r_pend_addr    <= 16'd0;
            r_length       <= 16'd0;
            r_addr         <= 16'd0;
            r_grant_cycles <= 16'd0;
            r_err          <= 1'b0;
        end else begin
            r_err <= 1'b0;

            // Requests arriving mid-transfer: queue one, refuse the rest
            if (w_mid_xfer) begin
                if (w_req_zero) begin
                    r_err <= 1'b1;
                end else if (w_req_ok) begin
                    if (r_pend_valid) begin
                        r_err <= 1'b1;
                    end else begin
                        r_pend_valid <= 1'b1;
                        r_pend_len   <= dev_length;
                        r_pend_addr  <= dev_address;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend_valid) begin
                        // Only reachable after a timeout left a queued request
                        r_length       <= r_pend_len;
                        r_addr         <= r_pend_addr;
                        r_grant_cycles <= 16'd0;
                        r_pend_valid   <= 1'b0;
                        r_state        <= S_START;
                        if (w_req_zero) begin
                            r_err <= 1'b1;
                        end else if (w_req_ok) begin
                            r_pend_valid <= 1'b1;
                            r_pend_len   <= dev_length;
                            r_pend_addr  <= dev_address;
                        end
                    end else if (w_req_zero) begin
                        r_err <= 1'b1;
                    end else if (w_req_ok) begin
                        r_length       <= dev_length;
                        r_addr         <= dev_address;
                        r_grant_cycles <= 16'd0;
                        r_state        <= S_START;
                    end
                end
                S_START: begin
                    r_to_cnt <= 8'd0;
                    r_state  <= S_WAIT_BR;
                end
                S_WAIT_BR: begin
                    if (br) begin
                        r_state <= S_WAIT_CPU;
                    end else if (r_to_cnt == 8'd254) begin
                        r_to_cnt <= 8'd255;
                        r_err    <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                S_WAIT_CPU: begin
                    if (!br) begin
                        r_state <= S_RELEASE;
                    end else if (!cpu_mem_active) begin
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (r_grant_cycles != 16'hFFFF) begin
                        r_grant_cycles <= r_grant_cycles + 16'd1;
                    end
                    if (!br) begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (r_pend_valid) begin
                        r_length       <= r_pend_len;
                        r_addr         <= r_pend_addr;
                        r_grant_cycles <= 16'd0;
                        r_pend_valid   <= 1'b0;
                        r_state        <= S_START;
                        if (dev_req) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_req_ok) begin
                        // Same-cycle capture and launch of a new request
                        r_length       <= dev_length;
                        r_addr         <= dev_address;
                        r_grant_cycles <= 16'd0;
                        r_state        <= S_START;
                    end else begin
                        if (w_req_zero) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: table of whole transfers plus hand-written
// timeout, zero-length, queueing and reset-in-grant sequences. Completed
// transfers are checked against an expected queue when dma_done appears.
module tb_dma_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        dev_req;
    logic [15:0] dev_length;
    logic [15:0] dev_address;
    logic        cpu_mem_active;
    logic        br;
    logic        begin_dma;
    logic [15:0] length;
    logic [15:0] target_address;
    logic        bg;
    logic        cpu_bus_hold;
    logic        dma_done;
    logic        dma_err;
    logic        busy;
    logic [15:0] grant_cycles;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int bg_cnt   = 0;
    int bg_total = 0;
    int inv_bad  = 0;

    // {length, target_address, grant_cycles, bg cycles seen}
    logic [63:0] exp_q[$];

    typedef struct {
        logic [15:0] len;
        logic [15:0] addr;
        int          br_delay;
        int          cpu_cycles;
        int          hold;
        logic [15:0] exp_grant;
    } vec_t;

    vec_t vecs[4];

    dma_bus_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .dev_req        (dev_req),
        .dev_length     (dev_length),
        .dev_address    (dev_address),
        .cpu_mem_active (cpu_mem_active),
        .br             (br),
        .begin_dma      (begin_dma),
        .length         (length),
        .target_address (target_address),
        .bg             (bg),
        .cpu_bus_hold   (cpu_bus_hold),
        .dma_done       (dma_done),
        .dma_err        (dma_err),
        .busy           (busy),
        .grant_cycles   (grant_cycles),
        .dbg_state      (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one clock edge, then settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and invariant monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            bg_cnt = 0;
        end else begin
            if (begin_dma) bg_cnt = 0;
            if (bg) begin
                bg_cnt++;
                bg_total++;
            end
            if (bg && !cpu_bus_hold) inv_bad++;
            if (dma_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dma_done", 64'd1, 64'd0);
                end else begin
                    check("xfer_result", {length, target_address, grant_cycles, bg_cnt[15:0]},
                          exp_q.pop_front());
                end
            end
        end
    end

    // Offer a single-cycle request; returns just after the sampling edge
    task automatic do_req(input logic [15:0] len, input logic [15:0] addr);
        dev_req     = 1'b1;
        dev_length  = len;
        dev_address = addr;
        step();
        dev_req     = 1'b0;
    endtask

    // Drive the DMA engine from the begin_dma cycle through the dma_done cycle
    task automatic serve(input int br_delay, input int cpu_cycles, input int hold);
        step();
        repeat (br_delay) step();
        br             = 1'b1;
        cpu_mem_active = (cpu_cycles != 0);
        step();
        check("hold_on_br", {63'd0, cpu_bus_hold}, 64'd1);
        check("no_bg_wait_cpu", {63'd0, bg}, 64'd0);
        for (int i = 0; i < cpu_cycles; i++) begin
            step();
            check("bg_blocked_by_cpu", {63'd0, bg}, 64'd0);
        end
        cpu_mem_active = 1'b0;
        step();
        check("bg_on_grant", {63'd0, bg}, 64'd1);
        repeat (hold - 1) step();
        br = 1'b0;
        step();
        check("done_on_release", {63'd0, dma_done}, 64'd1);
        check("bg_off_release", {62'd0, bg, cpu_bus_hold}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{len: 16'd12, addr: 16'h0020, br_delay: 1, cpu_cycles: 0, hold: 12, exp_grant: 16'd12};
        vecs[1] = '{len: 16'd5,  addr: 16'h1234, br_delay: 0, cpu_cycles: 3, hold: 4,  exp_grant: 16'd4};
        vecs[2] = '{len: 16'hFFFF, addr: 16'hFFFF, br_delay: 5, cpu_cycles: 1, hold: 1, exp_grant: 16'd1};
        vecs[3] = '{len: 16'd3,  addr: 16'h0000, br_delay: $urandom_range(0, 6),
                    cpu_cycles: $urandom_range(0, 4), hold: 7, exp_grant: 16'd7};

        // Reset, with a request held at the same time to check priority
        reset = 1'b1; dev_req = 1'b1; dev_length = 16'd9; dev_address = 16'h0abc;
        cpu_mem_active = 1'b0; br = 1'b1;
        step(); step();
        check("reset_outputs", {begin_dma, bg, cpu_bus_hold, dma_done, dma_err, busy}, 64'd0);
        check("reset_regs", {length, target_address, grant_cycles}, 64'd0);
        reset = 1'b0; dev_req = 1'b0; br = 1'b0;
        step();

        // Table-driven whole transfers
        foreach (vecs[k]) begin
            do_req(vecs[k].len, vecs[k].addr);
            check("begin_dma", {63'd0, begin_dma}, 64'd1);
            check("latched", {length, target_address}, {32'd0, vecs[k].len, vecs[k].addr});
            exp_q.push_back({vecs[k].len, vecs[k].addr, vecs[k].exp_grant, vecs[k].hold[15:0]});
            serve(vecs[k].br_delay, vecs[k].cpu_cycles, vecs[k].hold);
            step();
            check("idle_after_xfer", {dma_done, busy, begin_dma}, 64'd0);
        end

        // Zero-length request is refused without starting anything
        do_req(16'd0, 16'h0055);
        check("zero_len_err", {dma_err, begin_dma, busy}, 64'b100);
        check("zero_len_latch", {length, target_address}, {32'd0, 16'd3, 16'h0000});
        step();
        check("zero_len_err_pulse", {dma_err, busy}, 64'd0);

        // Timeout with br never asserted
        begin
            int seen;
            int bg_before;
            seen = 0;
            bg_before = bg_total;
            do_req(16'd4, 16'h0300);
            step();
            for (int i = 1; i <= 300; i++) begin
                step();
                if (dma_err) begin
                    seen = i;
                    break;
                end
            end
            check("timeout_cycles", seen, 64'd255);
            check("timeout_idle", {63'd0, busy}, 64'd0);
            check("timeout_no_bg", bg_total - bg_before, 64'd0);
            step();
            check("timeout_err_pulse", {63'd0, dma_err}, 64'd0);
        end

        // Queueing: second request pends, third is refused
        do_req(16'd6, 16'h0100);
        exp_q.push_back({16'd6, 16'h0100, 16'd5, 16'd5});
        step();
        br = 1'b1;
        step();
        step();
        check("queue_in_grant", {63'd0, bg}, 64'd1);
        do_req(16'd8, 16'h0040);
        check("queue_accept", {63'd0, dma_err}, 64'd0);
        do_req(16'd9, 16'h0080);
        check("queue_drop_err", {63'd0, dma_err}, 64'd1);
        repeat (2) step();
        br = 1'b0;
        step();
        check("queue_first_done", {63'd0, dma_done}, 64'd1);
        step();
        check("queue_restart", {begin_dma, length, target_address, grant_cycles},
              {15'd0, 1'b1, 16'd8, 16'h0040, 16'd0});
        exp_q.push_back({16'd8, 16'h0040, 16'd3, 16'd3});
        serve(0, 0, 3);
        step();
        check("queue_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a grant
        do_req(16'd10, 16'h0200);
        step();
        br = 1'b1;
        step();
        step();
        step();
        check("pre_reset_grant", {62'd0, bg, cpu_bus_hold}, 64'b11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_in_grant", {bg, cpu_bus_hold, busy, dma_done, grant_cycles}, 64'd0);
        br = 1'b0;
        step();
        check("reset_no_done", {dma_done, busy}, 64'd0);
        step();

        check("bg_implies_hold", inv_bad, 64'd0);
        check("queue_drained", exp_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 Port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 Port dev_req, input, 1 bit: external device transfer request, sampled each cycle.
REQ-004 Port dev_length, input, 16 bits: word count, valid when dev_req=1.
REQ-005 Port dev_address, input, 16 bits: memory base address, valid when dev_req=1.
REQ-006 Port cpu_mem_active, input, 1 bit: CPU memory stage is using the bus this cycle.
REQ-007 Port br, input, 1 bit: bus request from the DMA engine.
REQ-008 Port begin_dma, output, 1 bit: one-cycle command to the DMA engine.
REQ-009 Port length, output, 16 bits: latched word count for the active transfer.
REQ-010 Port target_address, output, 16 bits: latched base address for the active transfer.
REQ-011 Port bg, output, 1 bit: bus grant to the DMA engine.
REQ-012 Port cpu_bus_hold, output, 1 bit: CPU shall not start memory accesses while high.
REQ-013 Port dma_done, output, 1 bit: one-cycle completion interrupt to the CPU.
REQ-014 Port dma_err, output, 1 bit: one-cycle pulse on br timeout or dropped request.
REQ-015 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-016 Port grant_cycles, output, 16 bits: bg-high cycle count for the current or last transfer.

Function
REQ-017 FSM states: IDLE, START, WAIT_BR, WAIT_CPU, GRANT, RELEASE; all outputs are registered or decoded from state only, with no combinational path from inputs.
REQ-018 IDLE: dev_req=1 with dev_length!=0 -> latch length/target_address, clear grant_cycles, go START.
REQ-019 IDLE: dev_req=1 with dev_length==0 -> stay IDLE, pulse dma_err for 1 cycle, latches unchanged.
REQ-020 START: begin_dma=1 for exactly this one cycle; go WAIT_BR unconditionally.
REQ-021 WAIT_BR: 8-bit timeout counter cleared on entry, +1 per cycle; br=1 -> WAIT_CPU; count reaches 255 with br=0 -> pulse dma_err, go IDLE.
REQ-022 WAIT_CPU: cpu_bus_hold=1; cpu_mem_active=0 -> GRANT; else remain, with no timeout.
REQ-023 GRANT: bg=1, cpu_bus_hold=1, grant_cycles +1 per cycle, saturating at 16'hFFFF; br=0 -> RELEASE.
REQ-024 RELEASE: bg=0, cpu_bus_hold=0, dma_done=1 for one cycle; next IDLE, or START if a request is pending.
REQ-025 Latency: dev_req in IDLE at edge N -> begin_dma high during cycle N+1; br falling at edge M -> bg low and dma_done high during cycle M+1.
REQ-026 dev_req while not IDLE, with no request pending: capture dev_length/dev_address into a one-entry pending buffer; zero length is handled per REQ-019.
REQ-027 dev_req while not IDLE, with a request already pending: drop the new request, pulse dma_err, keep the original pending entry.
REQ-028 dev_req in RELEASE, with none pending: captured into pending and served from RELEASE.
REQ-029 Pending request launch: on RELEASE->START, move pending into length/target_address, clear pending, clear grant_cycles.
REQ-030 bg is never high outside GRANT; cpu_bus_hold is high only in WAIT_CPU and GRANT.
REQ-031 br dropping in WAIT_CPU: go to RELEASE without asserting bg; dma_done still pulses.

Reset
REQ-032 reset=1 at an edge: state IDLE; begin_dma, bg, cpu_bus_hold, dma_done, dma_err, busy all 0; length, target_address, grant_cycles 0; pending cleared; timeout counter 0.
REQ-033 Reset in any state, including GRANT: bg and cpu_bus_hold are 0 in the cycle after the reset edge; no dma_done is generated.
REQ-034 Reset has priority over dev_req, br and all other inputs in the same cycle.

Verification
REQ-035 Basic transfer: dev_req, length=12, addr=16'h0020; br 2 cycles after begin_dma; br held 12 cycles in GRANT -> begin_dma 1 cycle, bg for 12 cycles, grant_cycles=12, dma_done 1 cycle, busy returns 0.
REQ-036 CPU contention: cpu_mem_active=1 for 3 cycles after br rises -> cpu_bus_hold high immediately; bg rises only the cycle after cpu_mem_active falls.
REQ-037 Timeout: dev_req, length=4, with br never asserted -> dma_err pulse 255 cycles after entering WAIT_BR; then IDLE; bg never 1.
REQ-038 Queueing: second dev_req (length=8, addr=16'h0040) during GRANT; third dev_req also during GRANT -> third gives a dma_err pulse; after the first dma_done, START follows with length=8, target_address=16'h0040.
REQ-039 Zero length: dev_req with length=0 in IDLE -> dma_err 1 cycle; begin_dma stays 0; busy stays 0.
REQ-040 Reset mid-GRANT: reset high 1 cycle in GRANT -> next cycle bg=0, cpu_bus_hold=0, busy=0, dma_done=0, grant_cycles=0.
